// File: rtl/pu_ctrl_master_pkg.sv
// Pu_ctrl_pkg: shared types and constants for the PU controller-side master.
// Holds the wake FSM state type and the width of the wakeup timeout counter.
package Pu_ctrl_pkg;

    typedef enum logic [1:0] {
        AWAKE    = 2'd0,
        SLEEPING = 2'd1,
        WAKING   = 2'd2
    } Wake_state;

    // Width of the wakeup timeout counter; WAKE_TMO must fit in it.
    localparam int WAKE_TMO_W = 8;

endpackage

// File: rtl/pu_ctrl_if.sv
// Pu_ctrl_if: handshake bundle between a PU core and its controller.
// The ctrl modport drives level requests into the core and reads back the core's
// sleep/ack status and monitor taps; the pu modport is the mirror image.
interface Pu_ctrl_if;
    logic        wakeup;
    logic        doorbell;
    logic        ext_input;
    logic        sleep;
    logic        doorbell_ack;
    logic        ext_input_ack;
    logic        other_ack;
    logic        msr_ee;
    logic        iccr;
    logic [31:0] mon_pc;
    logic        mon_hold_dc;

    modport ctrl (
        output wakeup, doorbell, ext_input,
        input  sleep, doorbell_ack, ext_input_ack, other_ack, msr_ee, iccr, mon_pc, mon_hold_dc
    );

    modport pu (
        input  wakeup, doorbell, ext_input,
        output sleep, doorbell_ack, ext_input_ack, other_ack, msr_ee, iccr, mon_pc, mon_hold_dc
    );
endinterface

// File: rtl/pu_ctrl_master_edge_latch.sv
// pu_ctrl_edge_latch: per-source rising-edge capture of external interrupts.
// Enabled edges set a sticky pending bit; an ack clears every bit that was already
// latched, while an edge arriving in the ack cycle is kept.
module pu_ctrl_edge_latch #(
    parameter int N_EXT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_EXT-1:0] ext_irq,
    input  logic [N_EXT-1:0] ext_mask,
    input  logic             ack,
    output logic [N_EXT-1:0] pending,
    output logic [N_EXT-1:0] pending_next
);

    logic [N_EXT-1:0] ext_irq_q;
    logic [N_EXT-1:0] rise;

    assign rise         = ext_irq & ~ext_irq_q & ext_mask;
    assign pending_next = ack ? rise : (pending | rise);

    // Edge history and pending bits; both restart clean so pre-reset requests are lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            ext_irq_q <= '0;
            pending   <= '0;
        end else begin
            ext_irq_q <= ext_irq;
            pending   <= pending_next;
        end
    end

endmodule

// File: rtl/pu_ctrl_master.sv
// pu_ctrl_master: controller-side end of Pu_ctrl_if.
// Counts doorbells, latches external interrupt edges, presents both as level requests
// until acknowledged, and wakes a sleeping PU when work is pending.
// Optional monitor (mon_last_pc / mon_stall) is built only when PU_CTRL_MON_EN is defined;
// otherwise both outputs are tied to zero.
module pu_ctrl_master
    import Pu_ctrl_pkg::*;
#(
    parameter int N_EXT    = 4,
    parameter int DB_CNT_W = 4,
    parameter int WAKE_TMO = 255
) (
    input  logic                clk,
    input  logic                reset,
    Pu_ctrl_if.ctrl             ctrl,
    input  logic                db_set,
    input  logic [N_EXT-1:0]    ext_irq,
    input  logic [N_EXT-1:0]    ext_mask,
    input  logic                wake_req,
    output logic [DB_CNT_W-1:0] db_pending,
    output logic [N_EXT-1:0]    ext_pending,
    output logic                wake_tmo,
    output logic [31:0]         mon_last_pc,
    output logic [15:0]         mon_stall
);

    localparam logic [DB_CNT_W-1:0]   DB_MAX  = '1;
    localparam logic [WAKE_TMO_W-1:0] TMO_LIM = WAKE_TMO_W'(WAKE_TMO);

    logic [DB_CNT_W-1:0]   db_next;
    logic                  db_ack_eff;
    logic [N_EXT-1:0]      ext_next;
    logic                  work_pending;
    Wake_state             state;
    Wake_state             state_next;
    logic [WAKE_TMO_W-1:0] tmo_cnt;

    // msr_ee/iccr are deliberately not used for gating: the PU decides acceptance.
    logic unused_ifc;
    assign unused_ifc = ^{ctrl.other_ack, ctrl.msr_ee, ctrl.iccr};

    // Doorbell counter next value: saturating increment, ack ignored at zero,
    // simultaneous request and effective ack cancel out.
    always_comb begin
        db_next    = db_pending;
        db_ack_eff = ctrl.doorbell_ack && (db_pending != '0);
        if (db_set && !db_ack_eff) begin
            if (db_pending != DB_MAX) db_next = db_pending + DB_CNT_W'(1);
        end else if (!db_set && db_ack_eff) begin
            db_next = db_pending - DB_CNT_W'(1);
        end
    end

    // Doorbell count and its registered level request toward the PU.
    always_ff @(posedge clk) begin
        if (reset) begin
            db_pending    <= '0;
            ctrl.doorbell <= 1'b0;
        end else begin
            db_pending    <= db_next;
            ctrl.doorbell <= (db_next != '0);
        end
    end

    pu_ctrl_edge_latch #(
        .N_EXT (N_EXT)
    ) u_edge_latch (
        .clk          (clk),
        .reset        (reset),
        .ext_irq      (ext_irq),
        .ext_mask     (ext_mask),
        .ack          (ctrl.ext_input_ack),
        .pending      (ext_pending),
        .pending_next (ext_next)
    );

    // Combined external request level, registered alongside the pending bits.
    always_ff @(posedge clk) begin
        if (reset) ctrl.ext_input <= 1'b0;
        else       ctrl.ext_input <= |ext_next;
    end

    assign work_pending = (db_pending != '0) || (ext_pending != '0) || wake_req;

    // Wake FSM next state: only ever heads to WAKING while the PU reports sleep.
    always_comb begin
        state_next = state;
        case (state)
            AWAKE: begin
                if (ctrl.sleep) state_next = work_pending ? WAKING : SLEEPING;
            end
            SLEEPING: begin
                if (!ctrl.sleep)       state_next = AWAKE;
                else if (work_pending) state_next = WAKING;
            end
            WAKING: begin
                if (!ctrl.sleep) state_next = AWAKE;
            end
            default: state_next = AWAKE;
        endcase
    end

    // Wake FSM state, registered wakeup level, and the sticky timeout watchdog.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= AWAKE;
            ctrl.wakeup <= 1'b0;
            tmo_cnt     <= '0;
            wake_tmo    <= 1'b0;
        end else begin
            state       <= state_next;
            ctrl.wakeup <= (state_next == WAKING);
            if ((state == WAKING) && (state_next == WAKING)) begin
                if (tmo_cnt == TMO_LIM) begin
                    tmo_cnt  <= '0;
                    wake_tmo <= 1'b1;
                end else begin
                    tmo_cnt <= tmo_cnt + WAKE_TMO_W'(1);
                end
            end else begin
                tmo_cnt <= '0;
            end
        end
    end

`ifdef PU_CTRL_MON_EN
    // Monitor: track last retired PC and length of the current hold run.
    always_ff @(posedge clk) begin
        if (reset) begin
            mon_last_pc <= '0;
            mon_stall   <= '0;
        end else begin
            if (!ctrl.mon_hold_dc) mon_last_pc <= ctrl.mon_pc;
            if (ctrl.mon_hold_dc) begin
                if (mon_stall != 16'hffff) mon_stall <= mon_stall + 16'd1;
            end else begin
                mon_stall <= '0;
            end
        end
    end
`else
    logic unused_mon;
    assign unused_mon  = ^{ctrl.mon_pc, ctrl.mon_hold_dc};
    assign mon_last_pc = '0;
    assign mon_stall   = '0;
`endif

endmodule
